// File: rtl/button_conditioner.sv
// Multi-channel push-button conditioner: synchroniser, debouncer, press/release pulses,
// long-press detection and an auto-repeat pulse train per channel.
module button_conditioner #(
    parameter int CHANNELS        = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [CHANNELS-1:0]   i_btn_in,
    input  logic [CHANNELS-1:0]   i_repeat_en,
    output logic [CHANNELS-1:0]   o_level,
    output logic [CHANNELS-1:0]   o_press,
    output logic [CHANNELS-1:0]   o_release,
    output logic [CHANNELS-1:0]   o_long_press,
    output logic [CHANNELS-1:0]   o_rpt,
    output logic                  o_any_press,
    output logic [2*CHANNELS-1:0] o_hold_state
);

    localparam int DW   = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int TMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int TW   = $clog2(TMAX) + 1;

    localparam logic [DW-1:0] DCNT_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] DELAY_LAST  = TW'(REPEAT_DELAY - 1);
    localparam logic [TW-1:0] PERIOD_LAST = TW'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RPT  = 2'd2
    } hold_state_t;

    logic [SYNC_STAGES-1:0] r_sync  [CHANNELS];
    logic [DW-1:0]          r_dcnt  [CHANNELS];
    logic [TW-1:0]          r_timer [CHANNELS];
    hold_state_t            r_state [CHANNELS];

    logic [CHANNELS-1:0] r_level;
    logic [CHANNELS-1:0] r_press;
    logic [CHANNELS-1:0] r_release;
    logic [CHANNELS-1:0] r_long_press;
    logic [CHANNELS-1:0] r_rpt;
    logic                r_any_press;

    logic [CHANNELS-1:0] w_sync_out;
    logic [CHANNELS-1:0] w_toggle;
    logic [CHANNELS-1:0] w_rise;
    logic [CHANNELS-1:0] w_fall;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            for (int c = 0; c < CHANNELS; c++) r_sync[c] <= '0;
        end else begin
            for (int c = 0; c < CHANNELS; c++)
                r_sync[c] <= {r_sync[c][SYNC_STAGES-2:0], i_btn_in[c]};
        end
    end

    // A toggle is the edge on which the debounced level flips; rise/fall split it by direction.
    always_comb begin
        w_sync_out = '0;
        w_toggle   = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            w_sync_out[c] = r_sync[c][SYNC_STAGES-1];
            w_toggle[c]   = (w_sync_out[c] != r_level[c]) && (r_dcnt[c] == DCNT_LAST);
        end
        w_rise = w_toggle & ~r_level;
        w_fall = w_toggle & r_level;
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_level     <= '0;
            r_press     <= '0;
            r_release   <= '0;
            r_any_press <= 1'b0;
            for (int c = 0; c < CHANNELS; c++) r_dcnt[c] <= '0;
        end else begin
            r_press     <= w_rise;
            r_release   <= w_fall;
            r_any_press <= |w_rise;
            for (int c = 0; c < CHANNELS; c++) begin
                if (w_sync_out[c] == r_level[c]) begin
                    r_dcnt[c] <= '0;
                end else if (w_toggle[c]) begin
                    r_level[c] <= ~r_level[c];
                    r_dcnt[c]  <= '0;
                end else begin
                    r_dcnt[c] <= r_dcnt[c] + DW'(1);
                end
            end
        end
    end

    // Hold FSM: a release always wins, so no long_press/rpt escapes on the release edge.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_long_press <= '0;
            r_rpt        <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                r_state[c] <= S_IDLE;
                r_timer[c] <= '0;
            end
        end else begin
            r_long_press <= '0;
            r_rpt        <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                if (w_fall[c]) begin
                    r_state[c] <= S_IDLE;
                    r_timer[c] <= '0;
                end else begin
                    case (r_state[c])
                        S_IDLE: begin
                            if (w_rise[c]) begin
                                r_state[c] <= S_WAIT;
                                r_timer[c] <= '0;
                            end
                        end
                        S_WAIT: begin
                            if (r_timer[c] == DELAY_LAST) begin
                                r_long_press[c] <= 1'b1;
                                r_rpt[c]        <= i_repeat_en[c];
                                r_state[c]      <= S_RPT;
                                r_timer[c]      <= '0;
                            end else begin
                                r_timer[c] <= r_timer[c] + TW'(1);
                            end
                        end
                        S_RPT: begin
                            if (r_timer[c] == PERIOD_LAST) begin
                                r_rpt[c]   <= i_repeat_en[c];
                                r_timer[c] <= '0;
                            end else begin
                                r_timer[c] <= r_timer[c] + TW'(1);
                            end
                        end
                        default: begin
                            r_state[c] <= S_IDLE;
                            r_timer[c] <= '0;
                        end
                    endcase
                end
            end
        end
    end

    always_comb begin
        o_hold_state = '0;
        for (int c = 0; c < CHANNELS; c++) o_hold_state[2*c +: 2] = r_state[c];
    end

    assign o_level      = r_level;
    assign o_press      = r_press;
    assign o_release    = r_release;
    assign o_long_press = r_long_press;
    assign o_rpt        = r_rpt;
    assign o_any_press  = r_any_press;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner: a per-edge vector table for a full press/hold/release
// on channel 0, then hand-written sequences for bounce, masked repeat, dual press and reset.
module tb_button_conditioner;

    localparam int CH = 2;
    localparam int NV = 34;

    logic            clk;
    logic            rst;
    logic [CH-1:0]   btn_in;
    logic [CH-1:0]   repeat_en;
    logic [CH-1:0]   level;
    logic [CH-1:0]   press;
    logic [CH-1:0]   rel;
    logic [CH-1:0]   long_press;
    logic [CH-1:0]   rpt;
    logic            any_press;
    logic [2*CH-1:0] hold_state;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        logic [CH-1:0] btn;
        logic [CH-1:0] en;
        logic [CH-1:0] level;
        logic [CH-1:0] press;
        logic [CH-1:0] rel;
        logic [CH-1:0] lp;
        logic [CH-1:0] rpt;
        logic          any;
    } vec_t;

    vec_t vec [1:NV];

    button_conditioner #(
        .CHANNELS       (CH),
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (10),
        .REPEAT_PERIOD  (3)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_btn_in    (btn_in),
        .i_repeat_en (repeat_en),
        .o_level     (level),
        .o_press     (press),
        .o_release   (rel),
        .o_long_press(long_press),
        .o_rpt       (rpt),
        .o_any_press (any_press),
        .o_hold_state(hold_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " level"},      int'(level),      0);
        check({tag, " press"},      int'(press),      0);
        check({tag, " release"},    int'(rel),        0);
        check({tag, " long_press"}, int'(long_press), 0);
        check({tag, " rpt"},        int'(rpt),        0);
        check({tag, " any_press"},  int'(any_press),  0);
        check({tag, " hold_state"}, int'(hold_state), 0);
    endtask

    initial begin
        int press_cnt, press_at, rel_cnt, lp_cnt, lp_at, rpt_cnt, rpt_early, rpt_first, other_cnt;
        int any_cnt, both_at;

        // Channel 0 pressed before edge 1 and released before edge 25; repeat enabled.
        for (int i = 1; i <= NV; i++) begin
            vec[i].btn   = (i <= 24) ? 2'b01 : 2'b00;
            vec[i].en    = 2'b01;
            vec[i].level = (i >= 6 && i <= 29) ? 2'b01 : 2'b00;
            vec[i].press = 2'b00;
            vec[i].rel   = 2'b00;
            vec[i].lp    = 2'b00;
            vec[i].rpt   = 2'b00;
            vec[i].any   = 1'b0;
        end
        vec[6].press  = 2'b01;
        vec[6].any    = 1'b1;
        vec[16].lp    = 2'b01;
        vec[16].rpt   = 2'b01;
        vec[19].rpt   = 2'b01;
        vec[22].rpt   = 2'b01;
        vec[25].rpt   = 2'b01;
        vec[28].rpt   = 2'b01;
        vec[30].rel   = 2'b01;

        rst       = 1'b0;
        btn_in    = '0;
        repeat_en = '0;
        #2;
        check_all_zero("reset");
        tick();
        tick();
        rst = 1'b1;
        cyc = 0;

        for (int i = 1; i <= NV; i++) begin
            btn_in    = vec[i].btn;
            repeat_en = vec[i].en;
            tick();
            check($sformatf("vec%0d level", i),      int'(level),      int'(vec[i].level));
            check($sformatf("vec%0d press", i),      int'(press),      int'(vec[i].press));
            check($sformatf("vec%0d release", i),    int'(rel),        int'(vec[i].rel));
            check($sformatf("vec%0d long_press", i), int'(long_press), int'(vec[i].lp));
            check($sformatf("vec%0d rpt", i),        int'(rpt),        int'(vec[i].rpt));
            check($sformatf("vec%0d any_press", i),  int'(any_press),  int'(vec[i].any));
        end

        // Bounce: 1 x3, 0 x2, then stable 1 from k=6 -> press at k=11 only.
        repeat_en = '0;
        press_cnt = 0; press_at = -1; rel_cnt = 0;
        for (int k = 1; k <= 17; k++) begin
            btn_in = (k <= 3 || k >= 6) ? 2'b01 : 2'b00;
            tick();
            if (press[0]) begin press_cnt++; press_at = k; end
            if (rel[0]) rel_cnt++;
        end
        check("bounce press count", press_cnt, 1);
        check("bounce press edge", press_at, 11);
        check("bounce release count", rel_cnt, 0);
        btn_in = '0;
        repeat (25) tick();
        check("bounce settled level", int'(level), 0);

        // Channel 1 held with repeat masked; enable after edge P+20 (P=6) -> rpt from k=28.
        press_at = -1; lp_cnt = 0; lp_at = -1; rpt_cnt = 0; rpt_early = 0; rpt_first = -1;
        other_cnt = 0;
        btn_in    = 2'b10;
        repeat_en = 2'b00;
        for (int k = 1; k <= 66; k++) begin
            if (k == 27) repeat_en = 2'b10;
            tick();
            if (press[1]) press_at = k;
            if (long_press[1]) begin lp_cnt++; lp_at = k; end
            if (rpt[1]) begin
                rpt_cnt++;
                if (rpt_first < 0) rpt_first = k;
                if (k < 27) rpt_early++;
            end
            if (long_press[0] || rpt[0] || press[0]) other_cnt++;
        end
        check("mask press edge", press_at, 6);
        check("mask long_press count", lp_cnt, 1);
        check("mask long_press edge", lp_at, 16);
        check("mask rpt while disabled", rpt_early, 0);
        check("mask first rpt edge", rpt_first, 28);
        check("mask rpt count", rpt_cnt, 13);
        check("mask ch0 quiet", other_cnt, 0);
        btn_in    = '0;
        repeat_en = '0;
        repeat (25) tick();
        check("mask settled level", int'(level), 0);

        // Both channels pressed on the same edge.
        any_cnt = 0; both_at = -1; press_cnt = 0;
        btn_in = 2'b11;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (any_press) any_cnt++;
            if (press == 2'b11) both_at = k;
            if (press != 2'b00) press_cnt++;
        end
        check("dual press edge", both_at, 6);
        check("dual any_press cycles", any_cnt, 1);
        check("dual press cycles", press_cnt, 1);
        check("dual level", int'(level), 3);

        // Asynchronous reset mid-hold, button kept pressed through and after reset.
        #2;
        rst = 1'b0;
        #1;
        check_all_zero("async rst");
        tick();
        check_all_zero("rst held");
        rst = 1'b1;
        press_at = -1; press_cnt = 0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (press == 2'b11) press_at = k;
            if (press != 2'b00) press_cnt++;
        end
        check("post-rst press edge", press_at, 6);
        check("post-rst press cycles", press_cnt, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
